ccff_loader: RTL and testbench

Configuration-chain programmer: drives the `ccff_head` serial input of the fabric's configuration-flip-flop chain and samples its `ccff_tail` output. Sits between the bitstream byte source (host/SPI bridge) and the top of the chain threaded through all connection blocks, switch blocks and grid tiles. It produces the chain clock as a registered half-rate strobe. It also computes CRC-16 over both the bits shifted in and the bits returned from the tail, so a double load verifies the chain non-destructively.

---
 rtl/ccff_loader_pkg.sv | 23 ++
 rtl/ccff_loader_if.sv | 12 +
 rtl/ccff_crc16_serial.sv | 22 ++
 rtl/ccff_loader.sv | 135 +++++++++++++
 tb/tb_ccff_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared constants, state encoding and the bit-serial CRC-16/CCITT step
// for the configuration-chain loader.
package ccff_loader_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_t;

  // One CRC step: feedback is the outgoing MSB xor the new bit; no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Byte stream from the bitstream source into the loader.
// Handshake: a byte transfers on a rising clock edge where s_valid and
// s_ready are both high; the source must hold s_data/s_valid stable until
// that edge, and s_ready never depends on s_valid.
interface ccff_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16/CCITT accumulator with synchronous clear.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        din,
  output logic [15:0] crc
);

  // Clear to the init value, otherwise fold in one bit when enabled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain programmer: streams bytes LSB-first onto ccff_head
// with a registered half-rate chain clock, and keeps CRCs of the bits
// driven and of the bits returned from ccff_tail.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  ccff_loader_if.slave        src,
  output logic                chain_clk,
  output logic                ccff_head,
  input  logic                ccff_tail,
  output logic [15:0]         data_crc,
  output logic [15:0]         tail_crc,
  output state_t              dbg_state
);

  localparam int RW = $clog2(CHAIN_LEN + 1);

  state_t        state, next_state;
  logic [RW-1:0] remaining;
  logic [3:0]    nbits;
  logic [3:0]    nbits_load;
  logic [7:0]    sr;
  logic          hs;
  logic          crc_clear, crc_en;
  logic          busy_d, done_d, chain_clk_d, head_d;

  assign src.s_ready = (state == FETCH);
  assign hs          = src.s_valid && src.s_ready;
  assign dbg_state   = state;

  // Last byte may be partial; only the bits still owed to the chain are shifted.
  assign nbits_load = (32'(remaining) >= 32'd8) ? 4'd8 : 4'(remaining);

  // State register.
  always_ff @(posedge prog_clk) begin
    if (pReset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; SHIFT_HI decisions use the pre-decrement counters.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (start) next_state = FETCH;
      FETCH:    if (hs) next_state = SHIFT_LO;
      SHIFT_LO: next_state = SHIFT_HI;
      SHIFT_HI: begin
        if (remaining == RW'(1))  next_state = DONE;
        else if (nbits == 4'd1)   next_state = FETCH;
        else                      next_state = SHIFT_LO;
      end
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    busy_d      = (next_state != IDLE);
    done_d      = (state == DONE);
    chain_clk_d = (next_state == SHIFT_HI);
    head_d      = ccff_head;
    crc_clear   = (state == IDLE) && start;
    crc_en      = (state == SHIFT_LO);
    if (state == FETCH && hs) begin
      head_d = src.s_data[0];
    end else if (state == SHIFT_HI && next_state == SHIFT_LO) begin
      head_d = sr[1];
    end
  end

  // Output registers; head only changes entering SHIFT_LO so it is stable across LO+HI.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      chain_clk <= 1'b0;
      ccff_head <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      chain_clk <= chain_clk_d;
      ccff_head <= head_d;
    end
  end

  // Byte shift register and bit counters.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      remaining <= '0;
      nbits     <= '0;
      sr        <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) remaining <= RW'(CHAIN_LEN);
        FETCH: if (hs) begin
          sr    <= src.s_data;
          nbits <= nbits_load;
        end
        SHIFT_HI: begin
          sr        <= sr >> 1;
          nbits     <= nbits - 4'd1;
          remaining <= remaining - RW'(1);
        end
        default: ;
      endcase
    end
  end

  ccff_crc16_serial u_data_crc (
    .clk    (prog_clk),
    .rst    (pReset),
    .clear  (crc_clear),
    .enable (crc_en),
    .din    (sr[0]),
    .crc    (data_crc)
  );

  ccff_crc16_serial u_tail_crc (
    .clk    (prog_clk),
    .rst    (pReset),
    .clear  (crc_clear),
    .enable (crc_en),
    .din    (ccff_tail),
    .crc    (tail_crc)
  );

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: a 12-bit chain model on the main instance
// and an 8-bit instance for the all-zero byte CRC case.
module tb_ccff_loader;
  import ccff_loader_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic p_reset = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // 12-bit instance with chain model
  logic        start = 1'b0;
  logic        busy, done, chain_clk, ccff_head, ccff_tail;
  logic [15:0] data_crc, tail_crc;
  state_t      dut_state;
  ccff_loader_if bus ();

  ccff_loader #(.CHAIN_LEN(12)) dut (
    .prog_clk (clk), .pReset (p_reset), .start (start), .busy (busy), .done (done),
    .src (bus), .chain_clk (chain_clk), .ccff_head (ccff_head), .ccff_tail (ccff_tail),
    .data_crc (data_crc), .tail_crc (tail_crc), .dbg_state (dut_state)
  );

  logic [11:0] chain = '0;
  logic        corrupt = 1'b0;
  always @(posedge chain_clk or posedge corrupt) begin
    if (corrupt) chain <= chain ^ 12'h020;
    else         chain <= {chain[10:0], ccff_head};
  end
  assign ccff_tail = chain[11];

  int rises = 0;
  always @(posedge chain_clk) rises <= rises + 1;
  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // 8-bit instance, tail tied low
  logic        start8 = 1'b0;
  logic        busy8, done8, chain_clk8, head8;
  logic        tail8 = 1'b0;
  logic [15:0] data_crc8, tail_crc8;
  state_t      state8;
  ccff_loader_if bus8 ();

  ccff_loader #(.CHAIN_LEN(8)) dut8 (
    .prog_clk (clk), .pReset (p_reset), .start (start8), .busy (busy8), .done (done8),
    .src (bus8), .chain_clk (chain_clk8), .ccff_head (head8), .ccff_tail (tail8),
    .data_crc (data_crc8), .tail_crc (tail_crc8), .dbg_state (state8)
  );

  // Reference CRC over n bits; msb_first picks chain read-out order.
  function automatic logic [15:0] model_crc(input logic [15:0] v, input int n, input bit msb_first);
    logic [15:0] c;
    logic        b;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = msb_first ? v[n-1-i] : v[i];
      if (c[15] ^ b) c = (c << 1) ^ 16'h1021;
      else           c = c << 1;
    end
    return c;
  endfunction

  logic [15:0] exp_data_crc;
  logic [15:0] exp_zero_crc;
  logic [15:0] exp_bad_crc;

  // Driver: one load of bytes A5,03. stall = FETCH cycles with s_valid low
  // before byte 2; poke pulses start while busy and in DONE; abort raises
  // pReset during the 6th SHIFT_HI and returns immediately.
  task automatic run_load(input int stall, input bit poke, input bit abort,
                          output int done_rel, output int rises_n, output int pulses);
    int   c0, r0, d0, idx, stall_seen, hi_seen, rel;
    bit   hs, stalling;
    logic [7:0] bytes [2];
    bytes[0] = 8'hA5;
    bytes[1] = 8'h03;
    done_rel = -1;
    hs = 1'b0; stalling = 1'b0; idx = 0; stall_seen = 0; hi_seen = 0;
    @(negedge clk);
    r0 = rises; d0 = done_cnt; c0 = cyc;
    start = 1'b1;
    bus.s_data = bytes[0];
    bus.s_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx == 1 && stall > 0) begin
          bus.s_valid = 1'b0;
          stalling = 1'b1;
        end else if (idx < 2) begin
          bus.s_data = bytes[idx];
        end else begin
          bus.s_valid = 1'b0;
        end
      end else if (stalling && stall_seen == stall) begin
        bus.s_data = bytes[1];
        bus.s_valid = 1'b1;
        stalling = 1'b0;
      end
      @(negedge clk);
      rel = cyc - c0;
      start = poke && (rel == 5 || dut_state == DONE);
      if (rel == 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
      end
      if (stalling && (stall_seen > 0 || bus.s_ready === 1'b1)) begin
        total++;
        if (bus.s_ready !== 1'b1 || chain_clk !== 1'b0) begin
          bad++;
          $display("FAIL stall_cycle%0d: s_ready=%b chain_clk=%b want 1/0", stall_seen, bus.s_ready, chain_clk);
        end
        stall_seen++;
      end
      hs = bus.s_valid && bus.s_ready;
      if (chain_clk === 1'b1) hi_seen++;
      if (abort && hi_seen == 6) begin
        p_reset = 1'b1;
        start = 1'b0;
        break;
      end
      if (done === 1'b1) begin
        done_rel = rel;
        break;
      end
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    if (!abort) repeat (3) @(negedge clk);
    pulses  = done_cnt - d0;
    rises_n = rises - r0;
  endtask

  task automatic test_reset();
    start = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'h00;
    bus8.s_valid = 1'b0; bus8.s_data = 8'h00;
    p_reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)          begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (bus.s_ready !== 1'b0)   begin bad++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    total++; if (chain_clk !== 1'b0)     begin bad++; $display("FAIL rst_chain_clk: got %b want 0", chain_clk); end
    total++; if (ccff_head !== 1'b0)     begin bad++; $display("FAIL rst_head: got %b want 0", ccff_head); end
    total++; if (data_crc !== 16'hFFFF)  begin bad++; $display("FAIL rst_data_crc: got %h want ffff", data_crc); end
    total++; if (tail_crc !== 16'hFFFF)  begin bad++; $display("FAIL rst_tail_crc: got %h want ffff", tail_crc); end
    total++; if (dut_state !== IDLE)     begin bad++; $display("FAIL rst_state: got %0d want IDLE", dut_state); end
    p_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    int dr, rn, pc;
    run_load(0, 1'b0, 1'b0, dr, rn, pc);
    total++; if (dr != 28)                 begin bad++; $display("FAIL basic_done_cycle: got %0d want 28", dr); end
    total++; if (rn != 12)                 begin bad++; $display("FAIL basic_rises: got %0d want 12", rn); end
    total++; if (chain !== 12'hA5C)        begin bad++; $display("FAIL basic_chain: got %h want a5c", chain); end
    total++; if (data_crc !== exp_data_crc) begin bad++; $display("FAIL basic_data_crc: got %h want %h", data_crc, exp_data_crc); end
    total++; if (tail_crc !== exp_zero_crc) begin bad++; $display("FAIL basic_tail_crc: got %h want %h", tail_crc, exp_zero_crc); end
    total++; if (pc != 1)                  begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", pc); end
    total++; if (busy !== 1'b0)            begin bad++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_double_load();
    int dr, rn, pc;
    run_load(0, 1'b0, 1'b0, dr, rn, pc);
    total++; if (tail_crc !== exp_data_crc) begin bad++; $display("FAIL verify_tail_crc: got %h want %h", tail_crc, exp_data_crc); end
    total++; if (data_crc !== exp_data_crc) begin bad++; $display("FAIL verify_data_crc: got %h want %h", data_crc, exp_data_crc); end
    corrupt = 1'b1; #1; corrupt = 1'b0;
    run_load(0, 1'b0, 1'b0, dr, rn, pc);
    total++; if (tail_crc !== exp_bad_crc)  begin bad++; $display("FAIL corrupt_tail_crc: got %h want %h", tail_crc, exp_bad_crc); end
    total++; if (tail_crc === exp_data_crc) begin bad++; $display("FAIL corrupt_detect: got %h want not %h", tail_crc, exp_data_crc); end
    total++; if (chain !== 12'hA5C)         begin bad++; $display("FAIL corrupt_reload_chain: got %h want a5c", chain); end
  endtask

  task automatic test_stall();
    int dr, rn, pc;
    run_load(5, 1'b0, 1'b0, dr, rn, pc);
    total++; if (dr != 33)                  begin bad++; $display("FAIL stall_done_cycle: got %0d want 33", dr); end
    total++; if (rn != 12)                  begin bad++; $display("FAIL stall_rises: got %0d want 12", rn); end
    total++; if (chain !== 12'hA5C)         begin bad++; $display("FAIL stall_chain: got %h want a5c", chain); end
    total++; if (data_crc !== exp_data_crc) begin bad++; $display("FAIL stall_data_crc: got %h want %h", data_crc, exp_data_crc); end
  endtask

  task automatic test_zero_byte();
    int c0, dr, rel;
    dr = -1;
    @(negedge clk);
    c0 = cyc;
    start8 = 1'b1;
    bus8.s_data = 8'h00;
    bus8.s_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      rel = cyc - c0;
      start8 = 1'b0;
      if (done8 === 1'b1) begin dr = rel; break; end
    end
    bus8.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (dr != 19)               begin bad++; $display("FAIL zero_done_cycle: got %0d want 19", dr); end
    total++; if (data_crc8 !== 16'hE1F0) begin bad++; $display("FAIL zero_data_crc: got %h want e1f0", data_crc8); end
    total++; if (tail_crc8 !== 16'hE1F0) begin bad++; $display("FAIL zero_tail_crc: got %h want e1f0", tail_crc8); end
    total++; if (busy8 !== 1'b0)         begin bad++; $display("FAIL zero_busy_idle: got %b want 0", busy8); end
  endtask

  task automatic test_reset_mid_load();
    int dr, rn, pc, r0, d0;
    run_load(0, 1'b0, 1'b1, dr, rn, pc);
    @(negedge clk);
    total++; if (chain_clk !== 1'b0)    begin bad++; $display("FAIL abort_chain_clk: got %b want 0", chain_clk); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (data_crc !== 16'hFFFF) begin bad++; $display("FAIL abort_data_crc: got %h want ffff", data_crc); end
    total++; if (tail_crc !== 16'hFFFF) begin bad++; $display("FAIL abort_tail_crc: got %h want ffff", tail_crc); end
    total++; if (dut_state !== IDLE)    begin bad++; $display("FAIL abort_state: got %0d want IDLE", dut_state); end
    r0 = rises; d0 = done_cnt;
    p_reset = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    total++; if (rises != r0)    begin bad++; $display("FAIL abort_no_edges: got %0d rises want 0", rises - r0); end
    run_load(0, 1'b0, 1'b0, dr, rn, pc);
    total++; if (dr != 28)                  begin bad++; $display("FAIL reload_done_cycle: got %0d want 28", dr); end
    total++; if (rn != 12)                  begin bad++; $display("FAIL reload_rises: got %0d want 12", rn); end
    total++; if (chain !== 12'hA5C)         begin bad++; $display("FAIL reload_chain: got %h want a5c", chain); end
    total++; if (data_crc !== exp_data_crc) begin bad++; $display("FAIL reload_data_crc: got %h want %h", data_crc, exp_data_crc); end
  endtask

  task automatic test_start_ignored();
    int dr, rn, pc;
    run_load(0, 1'b1, 1'b0, dr, rn, pc);
    total++; if (pc != 1)             begin bad++; $display("FAIL poke_done_pulses: got %0d want 1", pc); end
    total++; if (dr != 28)            begin bad++; $display("FAIL poke_done_cycle: got %0d want 28", dr); end
    total++; if (rn != 12)            begin bad++; $display("FAIL poke_rises: got %0d want 12", rn); end
    total++; if (dut_state !== IDLE)  begin bad++; $display("FAIL poke_state_idle: got %0d want IDLE", dut_state); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL poke_busy_idle: got %b want 0", busy); end
  endtask

  initial begin
    exp_data_crc = model_crc({4'h0, 4'h3, 8'hA5}, 12, 1'b0);
    exp_zero_crc = model_crc(16'h0000, 12, 1'b0);
    exp_bad_crc  = model_crc({4'h0, 12'hA7C}, 12, 1'b1);
    test_reset();
    test_basic_load();
    test_double_load();
    test_stall();
    test_zero_byte();
    test_reset_mid_load();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
